// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks every register through one read port onto a valid/ready stream.
// Build with REGDUMP_CHECKSUM_EN to append an XOR checksum word after the last register.
module regfile_dump_reader #(
   parameter int NBITS = 32,
   parameter int NREGS = 32,
   parameter int AW    = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [AW-1:0]    rd_addr,
   input  logic [NBITS-1:0] rd_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [NBITS-1:0] out_data,
   output logic [AW-1:0]    out_addr,
   output logic             out_last,
   output logic             busy,
   output logic             done
);
   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] LOAD = 3'd1;
   localparam logic [2:0] SEND = 3'd2;
   localparam logic [2:0] DONE = 3'd3;
`ifdef REGDUMP_CHECKSUM_EN
   localparam logic [2:0] CSUM = 3'd4;
`endif
   localparam logic [AW-1:0] LAST = AW'(NREGS - 1);
   logic [2:0]    state;
   logic [AW-1:0] idx;
   logic          hs;
   assign hs      = out_valid & out_ready;
   assign rd_addr = idx;
   assign busy    = state != IDLE;
   assign done    = state == DONE;
`ifdef REGDUMP_CHECKSUM_EN
   logic [NBITS-1:0] csum;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) csum <= '0;
      else if (state == IDLE) csum <= '0;
      else if (state == LOAD) csum <= csum ^ rd_data;
   end
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_addr  <= '0;
         out_last  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               state <= LOAD;
               idx   <= '0;
            end
            LOAD: begin
               out_data  <= rd_data;
               out_addr  <= idx;
               out_valid <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
               out_last  <= 1'b0;
`else
               out_last  <= idx == LAST;
`endif
               state     <= SEND;
            end
            SEND: if (hs) begin
               out_valid <= 1'b0;
               out_last  <= 1'b0;
               if (idx == LAST) begin
`ifdef REGDUMP_CHECKSUM_EN
                  // checksum word is presented straight away, no extra load cycle
                  state     <= CSUM;
                  out_valid <= 1'b1;
                  out_data  <= csum;
                  out_addr  <= '0;
                  out_last  <= 1'b1;
`else
                  state <= DONE;
`endif
               end else begin
                  idx   <= idx + AW'(1);
                  state <= LOAD;
               end
            end
`ifdef REGDUMP_CHECKSUM_EN
            CSUM: if (hs) begin
               out_valid <= 1'b0;
               out_last  <= 1'b0;
               state     <= DONE;
            end
`endif
            DONE: begin
               state <= IDLE;
               idx   <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader: randomized scoreboard bench; expected words come from a snapshot of the register array at start.
module tb_regfile_dump_reader;
   localparam int N = 32;
`ifdef REGDUMP_CHECKSUM_EN
   localparam bit CS = 1'b1;
`else
   localparam bit CS = 1'b0;
`endif
   typedef struct {logic [31:0] d; logic [4:0] a; logic l; int nxt;} exp_t;
   logic clk = 0, rst_n = 1, start = 0, out_ready = 0;
   logic [4:0] rd_addr, out_addr;
   logic [31:0] rd_data, out_data;
   logic out_valid, out_last, busy, done;
   logic [31:0] rf [N];
   exp_t q[$];
   int checks = 0, failures = 0;
   bit rnd_ready = 0;
   int stall_addr = -1, stall_cnt = 0;
   always #5 clk = ~clk;
   assign rd_data = rf[rd_addr];
   regfile_dump_reader #(.NBITS(32), .NREGS(N), .AW(5)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .rd_addr(rd_addr), .rd_data(rd_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
      .out_last(out_last), .busy(busy), .done(done));
   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   // sink: optional 5-cycle stall on one address, otherwise always-ready or random
   always @(posedge clk) begin
      #1;
      if (stall_addr < 0) stall_cnt = 0;
      if (stall_addr >= 0 && out_valid && int'(out_addr) == stall_addr && stall_cnt < 5) begin
         out_ready = 0;
         stall_cnt++;
      end else out_ready = rnd_ready ? 1'($urandom_range(1)) : 1'b1;
   end
   exp_t e;
   logic [31:0] pd;
   logic [4:0] pa;
   logic pl;
   bit hold = 0, done_prev = 0;
   int gap = 0;
   always @(negedge clk) begin
      if (!rst_n) begin
         hold = 0; gap = 0; done_prev = 0;
      end else begin
         if (hold) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, pd);
            chk("hold_addr", out_addr, pa);
            chk("hold_last", out_last, pl);
         end
         if (gap == 2) begin chk("gap_idle", out_valid, 0); gap = 1; end
         else if (gap == 1) begin chk("gap_next_valid", out_valid, 1); gap = 0; end
         hold = 0;
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_word: got addr %0d data %h, expected no word", out_addr, out_data);
            end else begin
               e = q.pop_front();
               chk("word_data", out_data, e.d);
               chk("word_addr", out_addr, e.a);
               chk("word_last", out_last, e.l);
               gap = e.nxt;
            end
         end else if (out_valid) begin
            hold = 1; pd = out_data; pa = out_addr; pl = out_last;
         end
         if (done_prev) chk("done_width", done, 0);
         if (done) begin
            chk("done_queue_empty", q.size(), 0);
            chk("done_busy", busy, 1);
         end
         done_prev = done;
      end
   end
   task automatic push_dump();
      logic [31:0] x = '0;
      for (int k = 0; k < N; k++) begin
         q.push_back('{rf[k], 5'(k), !CS && k == N-1, k < N-1 ? 2 : (CS ? 1 : 0)});
         x ^= rf[k];
      end
      if (CS) q.push_back('{x, 5'd0, 1'b1, 0});
   endtask
   task automatic run_dump(output int n);
      push_dump();
      @(posedge clk); #1 start = 1;
      @(posedge clk); #1 start = 0;
      n = 0;
      forever begin
         @(negedge clk);
         if (done || n >= 4000) break;
         @(posedge clk); #1;
         n++;
      end
      if (n >= 4000) begin
         checks++; failures++;
         $display("FAIL dump_timeout: got no done after %0d cycles, expected done", n);
      end
      @(posedge clk);
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_valid", out_valid, 0);
   endtask
   task automatic wait_word(int a);
      for (int i = 0; i < 500 && !(out_valid && int'(out_addr) == a); i++) @(negedge clk);
      chk("reached_word", out_addr, a);
   endtask
   int n;
   initial begin
      for (int k = 0; k < N; k++) rf[k] = 32'(k) * 32'h01010101;
      #3 rst_n = 0; start = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_data", out_data, 0);
      chk("rst_rd_addr", rd_addr, 0);
      @(posedge clk); #1 start = 0; rst_n = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("post_rst_busy", busy, 0);
      run_dump(n);
      chk("dump_cycles", n, 2*N + int'(CS));
      stall_addr = 3;
      run_dump(n);
      chk("stall_cycles", n, 2*N + int'(CS) + 5);
      stall_addr = -1;
      fork
         run_dump(n);
         begin
            wait_word(7);
            rf[7] = 32'hDEADBEEF;
            start = 1;
            @(posedge clk); #1 start = 0;
         end
      join
      chk("busy_start_cycles", n, 2*N + int'(CS));
      rf[7] = 32'h07070707;
      push_dump();
      @(posedge clk); #1 start = 1;
      @(posedge clk); #1 start = 0;
      wait_word(10);
      rst_n = 0;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_data", out_data, 0);
      chk("arst_addr", out_addr, 0);
      chk("arst_last", out_last, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_rd_addr", rd_addr, 0);
      q.delete();
      @(posedge clk); #1 rst_n = 1;
      run_dump(n);
      chk("restart_cycles", n, 2*N + int'(CS));
      for (int k = 0; k < N; k++) rf[k] = '0;
      rf[1] = 32'hA5A5A5A5;
      rf[2] = 32'h0F0F0F0F;
      run_dump(n);
      rnd_ready = 1;
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < N; k++) rf[k] = $urandom;
         run_dump(n);
      end
      rnd_ready = 0;
      repeat (4) @(posedge clk);
      chk("queue_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish by 1000000, expected finish");
      $fatal(1, "watchdog");
   end
endmodule
